cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Miss-handling controller between the pipeline's L1 caches and the multi-cycle main memory. On a miss it locks the cache, issues one word-read per cycle for the 16-byte block containing the miss address, and writes each returned word into the data array. On the last word it also writes the tag array, then releases the cache. It sits directly below the CPU's instruction/data memory ports; one instance per cache, plus an external arbiter.

## Interface
Parameters:
- ADDR_W, 16, byte-address width
- BLOCK_WORDS, 8, 16-bit words per cache block (power of two; block bytes = 2*BLOCK_WORDS)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- miss_detected  in  1  cache miss on current access; level, held by cache until fsm_busy drops
- miss_address  in  ADDR_W  byte address of missing access
- memory_data_valid  in  1  one pulse per returned word, in request order
- memory_data  in  16  returned word, valid with memory_data_valid
- fsm_busy  out  1  fill in progress; pipeline stalls while high
- mem_req  out  1  read request to memory this cycle
- memory_address  out  ADDR_W  address for mem_req
- write_data_array  out  1  write memory_data into data array this cycle
- fill_address  out  ADDR_W  byte address of word being written (block base + 2*word index)
- write_tag_array  out  1  write tag/valid for block this cycle
- fill_done  out  1  one-cycle pulse, last word written

## Operation
- States: IDLE, FILL.
- IDLE: fsm_busy=0, mem_req=0, write strobes 0. If miss_detected=1: latch base = {miss_address[ADDR_W-1:4], 4'b0}; clear req_cnt and rcv_cnt; go to FILL.
- FILL: fsm_busy=1.
  - Requests: mem_req=1 while req_cnt<BLOCK_WORDS; memory_address = base + 2*req_cnt; req_cnt increments each cycle mem_req=1. Requests do not wait for returns.
  - Returns: on memory_data_valid, write_data_array=1, fill_address = base + 2*rcv_cnt, rcv_cnt increments.
  - Last return (rcv_cnt==BLOCK_WORDS-1 with valid): write_tag_array=1 and fill_done=1 in the same cycle; next state IDLE.
- miss_detected is ignored in FILL. A new miss cannot be accepted in the cycle FILL exits; earliest acceptance is the cycle after, in IDLE.
- memory_data_valid in IDLE is ignored: no strobes, no state change.
- Valid pulses beyond BLOCK_WORDS cannot occur, because FILL exits on the last one.
- Counters are log2(BLOCK_WORDS)+1 bits wide, so req_cnt saturates at BLOCK_WORDS. Address adds are modulo 2^ADDR_W; the block never crosses a block boundary.
- Outputs are decoded combinationally from state, counters and memory_data_valid. memory_address and fill_address are 0 when their strobe is low.

## Timing
- Reset (rst=1 at edge): state IDLE, counters 0, base 0. All outputs 0 the following cycle. Reset mid-fill aborts the fill with no tag write; returns still in flight are then ignored.
- Miss sampled at edge T: fsm_busy=1 and first mem_req during cycle T+1; requests in cycles T+1..T+8 at base+0..base+14.
- With 4-cycle memory latency, words return in T+5..T+12. write_data_array follows in T+5..T+12; write_tag_array/fill_done in T+12; fsm_busy=0 in T+13.
- Total stall = BLOCK_WORDS + latency cycles. Gaps in valid pulses only stretch the FILL state.
- Valid in the same cycle as a request is legal (zero-latency memory); both strobes assert together.

## Structure
- Shared package cache_pkg:
  - fill_state_t enum {IDLE, FILL}
  - BLOCK_WORDS and OFFSET_BITS=4, so the data/tag arrays and the arbiter use the same constants.
- Sub-module fill_counter: a synchronous-reset, enable/clear, saturating counter. It is instantiated twice (req_cnt, rcv_cnt).
- FSM, base register and address adders live in cache_fill_fsm.

## Test plan
- Reset, then idle 5 cycles: all outputs 0; memory_data_valid=1 with data 16'hDEAD produces no write strobes.
- Miss at 16'h1236, memory latency 4: requests at 16'h1230..16'h123E in cycles 1-8; writes at 16'h1230..16'h123E in cycles 5-12; write_tag_array + fill_done in cycle 12; fsm_busy low in cycle 13.
- Miss at 16'hFFFE: base 16'hFFF0, last request 16'hFFFE, no wrap into 16'h0000.
- Irregular returns (valid gaps of 0-3 cycles) on the 16'h0040 block: exactly 8 writes in order, tag write only on the 8th; second miss_detected pulses during FILL ignored.
- rst asserted after the 3rd returned word of the 16'h2000 fill: next cycle IDLE, fsm_busy=0, no tag write; the remaining 5 valids produce no strobes. A new miss at 16'h3000 then completes normally.
- Zero-latency memory (valid every cycle from cycle 1): mem_req and write_data_array coincide in cycles 1-8; fill_done in cycle 8.

Source files
------------

// File: rtl/cache_pkg.sv
// Constants and types shared by the fill controller, the data/tag arrays
// and the memory arbiter.
package cache_pkg;

    // 16-bit words per cache block
    localparam int BLOCK_WORDS = 8;

    // Byte-offset bits inside a block (16-byte block)
    localparam int OFFSET_BITS = 4;

    typedef enum logic {
        IDLE,
        FILL
    } fill_state_t;

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Synchronous-reset up-counter with clear and enable that holds at MAX.
module fill_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] SAT = WIDTH'(MAX);

    // count up on enable, stop at MAX, clear has priority over enable
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != SAT)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: streams one word request per cycle for the
// missing block, writes each returned word into the data array and writes
// the tag on the last word.
module cache_fill_fsm #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned BLOCK_WORDS = cache_pkg::BLOCK_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [15:0]       memory_data,
    output logic              fsm_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] fill_address,
    output logic              write_tag_array,
    output logic              fill_done
);

    import cache_pkg::*;

    localparam int unsigned    CW      = $clog2(BLOCK_WORDS) + 1;
    localparam logic [CW-1:0] REQ_END = CW'(BLOCK_WORDS);
    localparam logic [CW-1:0] LAST    = CW'(BLOCK_WORDS - 1);

    fill_state_t       state;
    logic [ADDR_W-1:0] base;
    logic [CW-1:0]     req_cnt;
    logic [CW-1:0]     rcv_cnt;
    logic              accept;
    logic              req_fire;
    logic              rcv_fire;
    logic              last_word;

    // Returned data goes straight from memory to the data array; only the
    // block-aligned part of the miss address is needed here.
    logic unused_bits;
    assign unused_bits = ^{memory_data, miss_address[OFFSET_BITS-1:0]};

    // handshake decode shared by the counters, the FSM and the outputs
    always_comb begin
        accept    = (state == IDLE) && miss_detected;
        req_fire  = (state == FILL) && (req_cnt < REQ_END);
        rcv_fire  = (state == FILL) && memory_data_valid;
        last_word = rcv_fire && (rcv_cnt == LAST);
    end

    fill_counter #(
        .WIDTH (CW),
        .MAX   (BLOCK_WORDS)
    ) u_req_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (req_fire),
        .count (req_cnt)
    );

    fill_counter #(
        .WIDTH (CW),
        .MAX   (BLOCK_WORDS)
    ) u_rcv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (rcv_fire),
        .count (rcv_cnt)
    );

    // state and block base: latch base on miss, leave FILL on last return
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            base  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base  <= {miss_address[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (last_word) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // output decode; addresses read as zero when their strobe is low
    always_comb begin
        fsm_busy         = (state == FILL);
        mem_req          = req_fire;
        memory_address   = req_fire ? (base + ADDR_W'({req_cnt, 1'b0})) : '0;
        write_data_array = rcv_fire;
        fill_address     = rcv_fire ? (base + ADDR_W'({rcv_cnt, 1'b0})) : '0;
        write_tag_array  = last_word;
        fill_done        = last_word;
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Testbench for cache_fill_fsm: a formula-built vector table, directed
// corner sequences and randomized fills against a queue-based model.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = '0;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] fill_address;
    logic        write_tag_array;
    logic        fill_done;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    typedef struct {
        logic        busy;
        logic        req;
        logic [15:0] maddr;
        logic        wda;
        logic [15:0] faddr;
        logic        tag;
        logic        done;
    } out_t;

    typedef struct {
        logic        rst;
        logic        miss;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] data;
        out_t        exp;
    } vec_t;

    // reference model: outstanding request and write addresses of the block
    bit          m_busy = 1'b0;
    logic [15:0] req_q[$];
    logic [15:0] fill_q[$];

    cache_fill_fsm #(
        .ADDR_W      (16),
        .BLOCK_WORDS (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_req           (mem_req),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_address      (fill_address),
        .write_tag_array   (write_tag_array),
        .fill_done         (fill_done)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input out_t e);
        cmp({tag, ".fsm_busy"},         16'(fsm_busy),         16'(e.busy));
        cmp({tag, ".mem_req"},          16'(mem_req),          16'(e.req));
        cmp({tag, ".memory_address"},   memory_address,        e.maddr);
        cmp({tag, ".write_data_array"}, 16'(write_data_array), 16'(e.wda));
        cmp({tag, ".fill_address"},     fill_address,          e.faddr);
        cmp({tag, ".write_tag_array"},  16'(write_tag_array),  16'(e.tag));
        cmp({tag, ".fill_done"},        16'(fill_done),        16'(e.done));
    endtask

    function automatic out_t model_expect();
        out_t e;
        e.busy  = m_busy;
        e.req   = m_busy && (req_q.size() != 0);
        e.maddr = e.req ? req_q[0] : 16'h0000;
        e.wda   = m_busy && memory_data_valid;
        e.faddr = e.wda ? fill_q[0] : 16'h0000;
        e.tag   = e.wda && (fill_q.size() == 1);
        e.done  = e.tag;
        return e;
    endfunction

    function automatic void model_update();
        logic [15:0] b;
        if (rst) begin
            m_busy = 1'b0;
            req_q.delete();
            fill_q.delete();
        end else if (!m_busy) begin
            if (miss_detected) begin
                b = miss_address & 16'hFFF0;
                for (int i = 0; i < 8; i++) begin
                    req_q.push_back(b + 16'(2 * i));
                    fill_q.push_back(b + 16'(2 * i));
                end
                m_busy = 1'b1;
            end
        end else begin
            if (req_q.size() != 0) void'(req_q.pop_front());
            if (memory_data_valid) begin
                void'(fill_q.pop_front());
                if (fill_q.size() == 0) m_busy = 1'b0;
            end
        end
    endfunction

    task automatic drive(input bit r, input bit m, input logic [15:0] a,
                         input bit v, input logic [15:0] d);
        @(negedge clk);
        rst               = r;
        miss_detected     = m;
        miss_address      = a;
        memory_data_valid = v;
        memory_data       = d;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
    endtask

    task automatic model_cycle(input string tag, input bit r, input bit m,
                               input logic [15:0] a, input bit v);
        drive(r, m, a, v, 16'($urandom));
        check_outputs(tag, model_expect());
        advance();
    endtask

    // one whole fill: returns scheduled after a latency plus random gaps
    task automatic run_fill(input string tag, input logic [15:0] a,
                            input int unsigned lat, input int unsigned maxgap,
                            input bit noisy);
        int unsigned ret[8];
        int unsigned t = 0;
        int unsigned k = 0;
        int unsigned writes = 0;
        int unsigned tags = 0;
        bit v;
        for (int i = 0; i < 8; i++) begin
            t = ((t + 1) > (i + 1 + lat)) ? (t + 1) : (i + 1 + lat);
            t = t + $urandom_range(0, maxgap);
            ret[i] = t;
        end
        model_cycle(tag, 1'b0, 1'b1, a, 1'b0);
        for (int unsigned c = 1; (k < 8) && (c < 200); c++) begin
            v = (ret[k] == c);
            drive(1'b0, noisy ? 1'($urandom) : 1'b1, noisy ? 16'($urandom) : a, v, 16'($urandom));
            check_outputs(tag, model_expect());
            if (write_data_array === 1'b1) writes++;
            if (write_tag_array === 1'b1) tags++;
            advance();
            if (v) k++;
        end
        model_cycle(tag, 1'b0, 1'b0, a, 1'b0);
        cmp({tag, ".write_count"}, 16'(writes), 16'd8);
        cmp({tag, ".tag_count"},   16'(tags),   16'd1);
    endtask

    vec_t tbl[$];

    initial begin
        vec_t        r;
        int unsigned tag_seen;

        // 4-cycle-latency fill of the 16'h1230 block, miss held while busy
        for (int c = 0; c <= 13; c++) begin
            r.rst       = 1'b0;
            r.miss      = (c <= 12);
            r.addr      = 16'h1236;
            r.valid     = (c >= 5) && (c <= 12);
            r.data      = 16'($urandom);
            r.exp.busy  = (c >= 1) && (c <= 12);
            r.exp.req   = (c >= 1) && (c <= 8);
            r.exp.maddr = r.exp.req ? 16'h1230 + 16'(2 * (c - 1)) : 16'h0000;
            r.exp.wda   = r.valid;
            r.exp.faddr = r.valid ? 16'h1230 + 16'(2 * (c - 5)) : 16'h0000;
            r.exp.tag   = (c == 12);
            r.exp.done  = (c == 12);
            tbl.push_back(r);
        end
        // zero-latency fill of the 16'h0500 block
        for (int c = 0; c <= 9; c++) begin
            r.rst       = 1'b0;
            r.miss      = (c <= 8);
            r.addr      = 16'h050A;
            r.valid     = (c >= 1) && (c <= 8);
            r.data      = 16'($urandom);
            r.exp.busy  = r.valid;
            r.exp.req   = r.valid;
            r.exp.maddr = r.valid ? 16'h0500 + 16'(2 * (c - 1)) : 16'h0000;
            r.exp.wda   = r.valid;
            r.exp.faddr = r.exp.maddr;
            r.exp.tag   = (c == 8);
            r.exp.done  = (c == 8);
            tbl.push_back(r);
        end

        // reset, then idle with stray valid/data that must be ignored
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        advance();
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hDEAD);
            check_outputs("reset_idle", model_expect());
            advance();
        end

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].miss, tbl[i].addr, tbl[i].valid, tbl[i].data);
            check_outputs($sformatf("table[%0d]", i), tbl[i].exp);
            advance();
        end

        run_fill("top_block", 16'hFFFE, 2, 0, 1'b0);
        run_fill("irregular", 16'h0040, 3, 3, 1'b1);

        // reset after the third returned word aborts the 16'h2000 fill
        tag_seen = 0;
        model_cycle("abort", 1'b0, 1'b1, 16'h2000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            model_cycle("abort", 1'b0, 1'b1, 16'h2000, 1'b1);
        end
        drive(1'b1, 1'b0, 16'h2000, 1'b0, 16'h0000);
        check_outputs("abort_rst", model_expect());
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'($urandom));
            check_outputs("abort_late", model_expect());
            if (write_tag_array === 1'b1) tag_seen++;
            advance();
        end
        cmp("abort.tag_count", 16'(tag_seen), 16'd0);
        run_fill("after_abort", 16'h3000, 4, 0, 1'b0);

        // randomized fills separated by idle cycles with stray returns
        for (int n = 0; n < 25; n++) begin
            for (int unsigned i = $urandom_range(0, 3); i > 0; i--) begin
                model_cycle("rand_idle", 1'b0, 1'b0, 16'($urandom), 1'($urandom));
            end
            run_fill($sformatf("rand_fill[%0d]", n), 16'($urandom),
                     $urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
